// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the div_ctrl clock-divider controller.
// Holds the FSM state type, default widths/ratio and the ratio sanitiser.
package div_ctrl_pkg;

    localparam int unsigned DefCntW = 26;
    localparam int unsigned DefDiv  = 25_000_000;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } div_state_t;

    // A ratio of 0 would underflow the terminal-count compare, so it is stored as 1.
    function automatic logic [31:0] ratio_fix(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Control/config bundle between a div_ctrl client (master) and div_ctrl (slave).
// The oneshot request exists only when DIV_CTRL_ONESHOT_EN is defined.
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) ();

    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             tick;
    logic             q;
    logic             running;
`ifdef DIV_CTRL_ONESHOT_EN
    logic             oneshot;

    modport master (
        output start, stop, cfg_valid, cfg_div, oneshot,
        input  cfg_ready, tick, q, running
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div, oneshot,
        output cfg_ready, tick, q, running
    );
`else
    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, tick, q, running
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, tick, q, running
    );
`endif

endinterface

// File: rtl/div_counter.sv
// Period counter: runs 0..div_i-1 while enabled and flags the terminal count.
// clr_i forces the count back to zero and takes priority over counting.
module div_counter
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // div_i is never zero, so the subtraction cannot wrap.
    assign tc_o = en_i && (cnt_q == (div_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Run/stop FSM, ratio handshake and square-wave output for the clock divider.
// Define DIV_CTRL_ONESHOT_EN to add the single-period (oneshot) run mode.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned DEF_DIV = DefDiv
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    div_ctrl_if.slave   bus
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             q_q, q_d;
    logic [CNT_W-1:0] cfg_fix;
    logic             tc, xfer, tick, leave_run, cnt_clr;
`ifdef DIV_CTRL_ONESHOT_EN
    logic             oneshot_q, oneshot_d;
`endif

    assign cfg_fix = CNT_W'(ratio_fix(32'(bus.cfg_div)));
    assign xfer    = bus.cfg_valid && !pend_q;

    div_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (state_q == StRun),
        .div_i  (active_q),
        .tc_o   (tc)
    );

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        q_d        = q_q;
        tick       = 1'b0;
        leave_run  = 1'b0;
        cnt_clr    = 1'b1;
`ifdef DIV_CTRL_ONESHOT_EN
        oneshot_d  = oneshot_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    active_d = cfg_fix;
                end
                if (bus.start && !bus.stop) begin
                    state_d = StRun;
                    q_d     = 1'b0;
`ifdef DIV_CTRL_ONESHOT_EN
                    oneshot_d = bus.oneshot;
`endif
                end
            end
            StRun: begin
                cnt_clr = 1'b0;
                if (bus.stop) begin
                    leave_run = 1'b1;
                    q_d       = 1'b0;
                end else if (tc) begin
                    tick = 1'b1;
                    q_d  = !q_q;
                    if (pend_q) begin
                        active_d = pend_div_q;
                        pend_d   = 1'b0;
                    end
`ifdef DIV_CTRL_ONESHOT_EN
                    if (oneshot_q) begin
                        leave_run = 1'b1;
                    end
`endif
                end
                // Leaving RUN must not strand a pending ratio in IDLE.
                if (leave_run) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                    if (pend_q) begin
                        active_d = pend_div_q;
                        pend_d   = 1'b0;
                    end else if (xfer) begin
                        active_d = cfg_fix;
                    end
                end else if (xfer) begin
                    pend_div_d = cfg_fix;
                    pend_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            active_q   <= CNT_W'(DEF_DIV);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            q_q        <= 1'b0;
`ifdef DIV_CTRL_ONESHOT_EN
            oneshot_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            q_q        <= q_d;
`ifdef DIV_CTRL_ONESHOT_EN
            oneshot_q  <= oneshot_d;
`endif
        end
    end

    assign bus.tick      = tick;
    assign bus.q         = q_q;
    assign bus.running   = (state_q == StRun);
    assign bus.cfg_ready = !pend_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl (CNT_W=8, DEF_DIV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_ctrl;

    localparam int unsigned CntW     = 8;
    localparam int unsigned DefDivTb = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_ctrl_if #(.CNT_W(CntW)) bus ();

    div_ctrl #(
        .CNT_W   (CntW),
        .DEF_DIV (DefDivTb)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
`ifdef DIV_CTRL_ONESHOT_EN
        bus.oneshot   = 1'b0;
`endif
    endtask

    task automatic cfg_idle(input logic [CntW-1:0] div);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = div;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.running, bus.tick, bus.q, bus.cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_hold: got run/tick/q/rdy=%b want 0001",
                     {bus.running, bus.tick, bus.q, bus.cfg_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd2;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        n_tests++;
        if (bus.cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pend_rdy: got %b want 0", bus.cfg_ready);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.running, bus.tick, bus.q, bus.cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_async: got run/tick/q/rdy=%b want 0001",
                     {bus.running, bus.tick, bus.q, bus.cfg_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // DEF_DIV=4 must be back in force; a surviving ratio 2 would tick early.
        for (int c = 1; c <= 8; c++) begin
            n_tests++;
            if (bus.tick !== ((c % 4) == 0)) begin
                n_fail++;
                $display("FAIL reset_def_div c=%0d: tick got %b want %b", c, bus.tick,
                         ((c % 4) == 0));
            end
            @(negedge clk);
        end
        do_stop();
    endtask

    task automatic test_free_run();
        int   nt;
        logic et;
        @(negedge clk);
        n_tests++;
        if (bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL free_run_idle_rdy: got %b want 1", bus.cfg_ready);
        end
        cfg_idle(8'd4);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nt = 0;
        for (int c = 1; c <= 13; c++) begin
            et = ((c % 4) == 0);
            n_tests++;
            if (bus.tick !== et || bus.q !== nt[0] || bus.running !== 1'b1) begin
                n_fail++;
                $display("FAIL free_run c=%0d: tick/q/run got %b%b%b want %b%b1", c,
                         bus.tick, bus.q, bus.running, et, nt[0]);
            end
            if (et) nt++;
            @(negedge clk);
        end
        do_stop();
        n_tests++;
        if (bus.running !== 1'b0 || bus.q !== 1'b0) begin
            n_fail++;
            $display("FAIL free_run_stop: run/q got %b%b want 00", bus.running, bus.q);
        end
    endtask

    task automatic test_cfg_change();
        int   nt;
        logic et, er;
        cfg_idle(8'd4);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nt = 0;
        for (int c = 1; c <= 19; c++) begin
            et = (c == 4 || c == 6 || c == 8 || c == 10 || c == 12 || c == 15 || c == 18);
            er = !(c == 3 || c == 4 || c == 11 || c == 12);
            n_tests++;
            if (bus.tick !== et || bus.q !== nt[0] || bus.cfg_ready !== er) begin
                n_fail++;
                $display("FAIL cfg_change c=%0d: tick/q/rdy got %b%b%b want %b%b%b", c,
                         bus.tick, bus.q, bus.cfg_ready, et, nt[0], er);
            end
            if (et) nt++;
            // Offer 2 mid-period, then 3 exactly on a terminal-count cycle.
            bus.cfg_valid = (c == 2 || c == 10);
            bus.cfg_div   = (c == 2) ? 8'd2 : 8'd3;
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        do_stop();
    endtask

    task automatic test_ratio_zero();
        int nt;
        cfg_idle(8'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nt = 0;
        for (int c = 1; c <= 6; c++) begin
            n_tests++;
            if (bus.tick !== 1'b1 || bus.q !== nt[0]) begin
                n_fail++;
                $display("FAIL ratio_zero c=%0d: tick/q got %b%b want 1%b", c, bus.tick,
                         bus.q, nt[0]);
            end
            nt++;
            @(negedge clk);
        end
        do_stop();
    endtask

    task automatic test_stop_start();
        cfg_idle(8'd4);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        // Cycle 7: cnt=2 of the second period, q=1.
        n_tests++;
        if (bus.q !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_start_pre_q: got %b want 1", bus.q);
        end
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        n_tests++;
        if ({bus.running, bus.q, bus.tick} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_start_idle: run/q/tick got %b want 000",
                     {bus.running, bus.q, bus.tick});
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_tests++;
            if (bus.tick !== (c == 4) || bus.running !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_start_restart c=%0d: tick/run got %b%b want %b1", c,
                         bus.tick, bus.running, (c == 4));
            end
            if (c < 4) @(negedge clk);
        end
        // Stop on a terminal-count cycle suppresses the tick.
        bus.stop = 1'b1;
        #1;
        n_tests++;
        if (bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_tc_tick: got %b want 0", bus.tick);
        end
        @(negedge clk);
        bus.stop = 1'b0;
        n_tests++;
        if (bus.running !== 1'b0 || bus.q !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_tc_idle: run/q got %b%b want 00", bus.running, bus.q);
        end
        // A pending ratio is applied by stop.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd2;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.stop      = 1'b1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.tick !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_pend_c1: tick/rdy got %b%b want 01", bus.tick, bus.cfg_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_pend_c2: tick got %b want 1", bus.tick);
        end
        @(negedge clk);
        do_stop();
    endtask

`ifdef DIV_CTRL_ONESHOT_EN
    task automatic test_oneshot();
        cfg_idle(8'd3);
        bus.start   = 1'b1;
        bus.oneshot = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.oneshot = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_tests++;
            if (bus.running !== (c <= 3) || bus.tick !== (c == 3) || bus.q !== (c >= 4)) begin
                n_fail++;
                $display("FAIL oneshot c=%0d: run/tick/q got %b%b%b want %b%b%b", c,
                         bus.running, bus.tick, bus.q, (c <= 3), (c == 3), (c >= 4));
            end
            @(negedge clk);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.running !== 1'b1 || bus.q !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_restart: run/q got %b%b want 10", bus.running, bus.q);
        end
        do_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_cfg_change();
        test_ratio_zero();
        test_stop_start();
`ifdef DIV_CTRL_ONESHOT_EN
        test_oneshot();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Run/stop controller and configuration sequencer for the programmable clock divider that generates the design's slow clocks (e.g. 1 Hz from 50 MHz). Owns the divide ratio, accepts ratio changes through a valid/ready handshake and applies them glitch-free on a period boundary. Emits a one-cycle `tick` enable and a 50 % duty square wave `q` for downstream consumers.

## Interface
- `CNT_W`, 26, counter and ratio width.
- `DEF_DIV`, 25_000_000, ratio loaded at reset (half-period of `q` in `clk` cycles).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts counting from IDLE.
- `stop`  in  1  level-sampled; returns to IDLE.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_div`  in  CNT_W  offered ratio.
- `cfg_ready`  out  1  ratio can be accepted this cycle.
- `tick`  out  1  one-cycle pulse at terminal count.
- `q`  out  1  toggles once per tick.
- `running`  out  1  high in RUN.

## Operation
- States: IDLE, RUN.
- Registers: `active_div`, `pend_div`, `pend` flag, counter `cnt`.
- Reset values: state IDLE, `cnt`=0, `active_div`=DEF_DIV, `pend`=0, `tick`=0, `q`=0, `running`=0, `cfg_ready`=1.
- Ratio rule: `cfg_div`=0 stored as 1. The counter runs 0..`active_div`-1.
- IDLE:
  - `cfg_valid` loads `active_div` directly.
  - `start`=1 and `stop`=0 moves to RUN with `cnt`=0.
- RUN:
  - `cnt` increments each cycle.
  - When `cnt`==`active_div`-1: `tick`=1 that cycle, `cnt`<=0, `q` toggles on the same edge.
  - If `pend`=1 at that terminal cycle: `active_div`<=`pend_div` and `pend`<=0.
- Handshake:
  - `cfg_ready` = !`pend`.
  - Transfer occurs when `cfg_valid`&&`cfg_ready`.
  - In RUN, a transfer writes `pend_div` and sets `pend`.
  - A transfer on a terminal-count cycle is applied at the following terminal count, never the current one.
  - While `pend`=1, `cfg_ready`=0 and offers are held off.
- `stop` (any state, wins over `start` and over terminal count):
  - Next state IDLE; `cnt`<=0, `q`<=0, `tick` suppressed.
  - If `pend`=1: `active_div`<=`pend_div`, `pend`<=0.
- Reset asserted mid-operation: all registers return to reset values immediately. No pending ratio survives.
- Arithmetic: unsigned CNT_W. Compare uses `active_div`-1, computed without wrap because 0 is never stored.

## Timing
- `start` sampled high at edge E0:
  - `running`=1 after E0, with `cnt`=0.
  - First `tick` is high during the cycle after edge E0+`active_div`-1 (i.e. `active_div` cycles after `running` rises).
  - `q` changes on the edge ending the tick cycle.
- `tick` is combinational from `cnt`/state (registered compare allowed if the cycle position is kept identical).
- Period: `tick` every `active_div` cycles. `q` period is 2×`active_div`.
- With `active_div`=1, `tick` stays high every RUN cycle and `q` toggles every edge.
- `cfg_ready` drops the cycle after an in-RUN transfer and rises the cycle after the applying tick.
- `stop`: `running`=0 and `q`=0 one edge after it is sampled.

## Configuration
- Macro `DIV_CTRL_ONESHOT_EN`.
- Defined:
  - Adds input port `oneshot` (1 bit), sampled together with `start`.
  - If it is 1 at start, the block runs exactly one period.
  - At the first terminal count it emits `tick`, toggles `q`, then returns to IDLE; `q` holds its toggled value until the next start or stop.
- Undefined: the port is absent, and the block is free-running only.

## Structure
- Package `div_ctrl_pkg`:
  - state enum `div_state_t` {IDLE, RUN};
  - default CNT_W and DEF_DIV constants;
  - helper function mapping ratio 0 to 1.
- Sub-module `div_counter`:
  - contains `cnt`, its clear/enable inputs, the `active_div` compare and the terminal-count output.
  - `div_ctrl` holds the FSM, handshake and `q`.

## Test plan
- Reset: hold `reset`=0 mid-run, then release -> `q`=0, `tick`=0, `running`=0, `cfg_ready`=1, `active_div`=DEF_DIV (bench uses DEF_DIV=4).
- IDLE cfg 4 then start at E0 -> `tick` during cycles E0+4, E0+8, E0+12; `q` 0->1->0->1.
- RUN at ratio 4, cfg 2 offered mid-period -> `cfg_ready` low until the next tick; subsequent ticks 2 cycles apart.
- cfg 0 -> behaves as ratio 1: `tick` held high, `q` toggles every cycle.
- `stop`+`start` together during RUN at `cnt`=2 -> IDLE next cycle, `q`=0, no tick; then `start` restarts with `cnt`=0.
- With `DIV_CTRL_ONESHOT_EN`, ratio 3, `oneshot`=1 -> single tick 3 cycles after `running` rises, `running` falls the next edge, `q`=1 held.
